// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - ALU function-select codes, status bit indices and sequencer states
package alu_seq_pkg;

  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_OR   = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_SHL  = 5'b10000;
  localparam logic [4:0] FS_SHR  = 5'b10100;
  localparam logic [4:0] FS_ZERO = 5'b11000;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier sequencer driving the shared LEGv8 ALU (low 64 product bits)
// Optional early exit on a zero shifted multiplier: define ALU_MUL_EARLY_EXIT_EN.
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             last_iter;

  // Only Z is consulted, and only when early exit is built in.
  logic unused_status;
  assign unused_status = ^alu_status;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign product = acc;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_iter = (count == CW'(WIDTH - 1)) || alu_status[ST_Z];
`else
  assign last_iter = (count == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
            count  <= '0;
          end
        end
        S_ADD: acc   <= alu_F;
        S_SHL: mcand <= alu_F;
        S_SHR: begin
          mplier <= alu_F;
          count  <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Each state borrows the ALU for exactly one operation; alu_F is taken at the closing edge.
  always_comb begin
    state_next = state;
    alu_A      = '0;
    alu_B      = '0;
    alu_FS     = FS_ZERO;
    alu_C0     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = multiplier[0] ? S_ADD : S_SHL;
      end
      S_ADD: begin
        alu_A      = acc;
        alu_B      = mcand;
        alu_FS     = FS_ADD;
        state_next = S_SHL;
      end
      S_SHL: begin
        alu_A      = mcand;
        alu_B      = WIDTH'(1);
        alu_FS     = FS_SHL;
        state_next = S_SHR;
      end
      S_SHR: begin
        alu_A  = mplier;
        alu_B  = WIDTH'(1);
        alu_FS = FS_SHR;
        if (last_iter)     state_next = S_DONE;
        else if (alu_F[0]) state_next = S_ADD;
        else               state_next = S_SHL;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

endmodule
